// File: rtl/booth_arb_pkg.sv
// Shared types and width helpers for the Booth multiplier arbiter.
// Exports: state_t (IDLE..CAPTURE), default NREQ/WIDTH, prod_w().
package booth_arb_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        CLEAR,
        RUN,
        CAPTURE
    } state_t;

    // Multiplier product bus carries one extra sign bit.
    function automatic int prod_w(input int w);
        return 2 * w + 1;
    endfunction

endpackage

// File: rtl/booth_mul_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after ptr.
// Ports: req, ptr in; grant (one-hot), idx, any out.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   idx,
    output logic            any
);

    logic found;
    int   j;

    assign any = |req;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = PW'(j);
            end
        end
    end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Shares one signed Booth multiplier among NREQ requesters (round robin).
// Ports: clk, reset_n, req_*/resp_* requester side, mul_* multiplier side,
// busy. Optional BOOTH_ZERO_BYPASS_EN: zero operand skips the multiplier.
module booth_mul_arbiter
    import booth_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         req_ack,
    output logic [NREQ-1:0]         resp_valid,
    output logic [2*WIDTH-1:0]      resp_data,
    output logic                    busy,
    output logic                    mul_reset,
    output logic                    mul_start,
    output logic [WIDTH-1:0]        mul_multiplier,
    output logic [WIDTH-1:0]        mul_multiplicand,
    input  logic [prod_w(WIDTH)-1:0] mul_product,
    input  logic                    mul_done
);

    localparam int PW = $clog2(NREQ);

    state_t            state;
    state_t            state_nx;
    logic [PW-1:0]     ptr;
    logic [NREQ-1:0]   gnt_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [2*WIDTH-1:0] data_q;
    logic [NREQ-1:0]   pick;
    logic [PW-1:0]     pick_idx;
    logic              pick_any;
    logic              zero_op;
    logic              unused_sign;

    // Top product bit is pure sign extension.
    assign unused_sign = mul_product[2*WIDTH];

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (pick),
        .idx   (pick_idx),
        .any   (pick_any)
    );

`ifdef BOOTH_ZERO_BYPASS_EN
    assign zero_op = (a_q == '0) || (b_q == '0);
`else
    assign zero_op = 1'b0;
`endif

    assign mul_multiplier   = a_q;
    assign mul_multiplicand = b_q;
    assign resp_data        = data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        req_ack    = '0;
        resp_valid = '0;
        busy       = 1'b1;
        mul_reset  = 1'b1;
        mul_start  = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (pick_any) state_nx = GRANT;
            end
            GRANT: begin
                req_ack  = gnt_q;
                state_nx = zero_op ? CAPTURE : CLEAR;
            end
            CLEAR: begin
                state_nx = RUN;
            end
            RUN: begin
                mul_reset = 1'b0;
                mul_start = 1'b1;
                if (mul_done) state_nx = CAPTURE;
            end
            CAPTURE: begin
                resp_valid = gnt_q;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operands are latched at the IDLE sampling edge, so they are already
    // stable on mul_* while req_ack is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr    <= '0;
            gnt_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            data_q <= '0;
        end else begin
            if (state == IDLE && pick_any) begin
                gnt_q <= pick;
                a_q   <= req_a[int'(pick_idx)*WIDTH +: WIDTH];
                b_q   <= req_b[int'(pick_idx)*WIDTH +: WIDTH];
                ptr   <= (pick_idx == PW'(NREQ-1)) ? '0
                                                   : pick_idx + PW'(1);
            end
            if (state == GRANT && zero_op)
                data_q <= '0;
            if (state == RUN && mul_done)
                data_q <= mul_product[2*WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed bench for booth_mul_arbiter with a behavioural multiplier.
// Checks grants, products, latency, reset abort and fairness.
module tb_booth_mul_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [3:0]  req_ack;
    logic [3:0]  resp_valid;
    logic [15:0] resp_data;
    logic        busy;
    logic        mul_reset;
    logic        mul_start;
    logic [7:0]  mul_multiplier;
    logic [7:0]  mul_multiplicand;
    logic signed [16:0] mul_product = '0;
    logic        mul_done = 1'b0;
    logic [3:0]  mcnt = '0;
    int          start_cnt = 0;

    int total = 0;
    int bad = 0;

    booth_mul_arbiter dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_a            (req_a),
        .req_b            (req_b),
        .req_ack          (req_ack),
        .resp_valid       (resp_valid),
        .resp_data        (resp_data),
        .busy             (busy),
        .mul_reset        (mul_reset),
        .mul_start        (mul_start),
        .mul_multiplier   (mul_multiplier),
        .mul_multiplicand (mul_multiplicand),
        .mul_product      (mul_product),
        .mul_done         (mul_done)
    );

    always #5 clk = ~clk;

    // External multiplier: done (sticky) after three start cycles.
    always @(posedge clk) begin
        if (mul_reset) begin
            mcnt        <= '0;
            mul_done    <= 1'b0;
            mul_product <= '0;
        end else if (mul_start && !mul_done) begin
            if (mcnt == 4'd2) begin
                mul_done    <= 1'b1;
                mul_product <= $signed(mul_multiplier)
                             * $signed(mul_multiplicand);
            end else begin
                mcnt <= mcnt + 4'd1;
            end
        end
    end

    always @(posedge clk) begin
        if (mul_start === 1'b1) start_cnt <= start_cnt + 1;
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i,
                          input logic [7:0] a,
                          input logic [7:0] b);
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
    endtask

    task automatic service(input string tag,
                           input logic [3:0] exp_g,
                           input logic [7:0] exp_a,
                           input logic [7:0] exp_b,
                           input logic [15:0] exp_d,
                           output int lat);
        int   n;
        logic got;
        n = 0;
        got = 1'b0;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            if (req_ack != '0) got = 1'b1;
        end
        chk({tag, "_ack"}, 32'(req_ack), 32'(exp_g));
        chk({tag, "_opa"}, 32'(mul_multiplier), 32'(exp_a));
        chk({tag, "_opb"}, 32'(mul_multiplicand), 32'(exp_b));
        for (int i = 0; i < 4; i++)
            if (exp_g[i]) set_op(i, 8'h5A, 8'hA5);
        got = 1'b0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            if (resp_valid != '0) got = 1'b1;
        end
        chk({tag, "_vld"}, 32'(resp_valid), 32'(exp_g));
        chk({tag, "_data"}, 32'(resp_data), 32'(exp_d));
        req_valid = req_valid & ~exp_g;
        lat = n;
    endtask

    initial begin
        int lat;
        int n;
        int s0;
        int prev;
        int rep;
        int cnt[4];
        logic got;

        // Reset state
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mreset", 32'(mul_reset), 32'd1);
        chk("rst_mstart", 32'(mul_start), 32'd0);
        chk("rst_ack", 32'(req_ack), 32'd0);
        chk("rst_vld", 32'(resp_valid), 32'd0);
        chk("rst_data", 32'(resp_data), 32'd0);
        chk("rst_opa", 32'(mul_multiplier), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Single request, -10 * 11
        set_op(0, 8'hF6, 8'h0B);
        req_valid = 4'b0001;
        service("t1", 4'b0001, 8'hF6, 8'h0B, 16'hFF92, lat);
        chk("t1_lat", 32'(lat), 32'd7);
        chk("t1_busy_cap", 32'(busy), 32'd1);
        @(negedge clk);
        chk("t1_busy_end", 32'(busy), 32'd0);

        // Single request, 14 * 13
        set_op(1, 8'd14, 8'd13);
        req_valid = 4'b0010;
        service("t2", 4'b0010, 8'd14, 8'd13, 16'h00B6, lat);
        @(negedge clk);
        chk("t2_busy_end", 32'(busy), 32'd0);

        // Reset to bring ptr back to 0, then req0+req2 together
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        set_op(0, 8'd3, 8'd5);
        set_op(2, 8'hFE, 8'd7);
        req_valid = 4'b0101;
        service("d0", 4'b0001, 8'd3, 8'd5, 16'h000F, lat);
        service("d2", 4'b0100, 8'hFE, 8'd7, 16'hFFF2, lat);
        @(negedge clk);

        // ptr now 3: req0+req3 serviced 3 then 0
        set_op(0, 8'd4, 8'd4);
        set_op(3, 8'hFD, 8'hFD);
        req_valid = 4'b1001;
        service("e3", 4'b1000, 8'hFD, 8'hFD, 16'h0009, lat);
        service("e0", 4'b0001, 8'd4, 8'd4, 16'h0010, lat);
        @(negedge clk);

        // Extremes
        set_op(1, 8'h80, 8'h80);
        req_valid = 4'b0010;
        service("x1", 4'b0010, 8'h80, 8'h80, 16'h4000, lat);
        @(negedge clk);
        set_op(2, 8'h7F, 8'h80);
        req_valid = 4'b0100;
        service("x2", 4'b0100, 8'h7F, 8'h80, 16'hC080, lat);
        @(negedge clk);

        // Reset asserted during RUN
        set_op(0, 8'd5, 8'd5);
        req_valid = 4'b0001;
        n = 0;
        while (mul_start !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ab_run", 32'(mul_start), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("ab_mreset", 32'(mul_reset), 32'd1);
        chk("ab_mstart", 32'(mul_start), 32'd0);
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_data", 32'(resp_data), 32'd0);
        got = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (resp_valid != '0) got = 1'b1;
        end
        chk("ab_novld", 32'(got), 32'd0);
        req_valid = '0;
        reset_n = 1'b1;
        @(negedge clk);

        // ptr must be 0 again: req0 before req1
        set_op(0, 8'd24, 8'd34);
        set_op(1, 8'd2, 8'd3);
        req_valid = 4'b0011;
        service("r0", 4'b0001, 8'd24, 8'd34, 16'h0330, lat);
        service("r1", 4'b0010, 8'd2, 8'd3, 16'h0006, lat);
        @(negedge clk);

        // Zero operand
        set_op(0, 8'd0, 8'd98);
        req_valid = 4'b0001;
        s0 = start_cnt;
        service("z", 4'b0001, 8'd0, 8'd98, 16'h0000, lat);
`ifdef BOOTH_ZERO_BYPASS_EN
        chk("z_lat", 32'(lat), 32'd2);
        chk("z_nostart", 32'(start_cnt - s0), 32'd0);
`else
        chk("z_lat", 32'(lat), 32'd7);
        chk("z_started", 32'(start_cnt > s0), 32'd1);
`endif
        @(negedge clk);

        // Fairness soak: all held high for 40 grants
        for (int i = 0; i < 4; i++) begin
            cnt[i] = 0;
            set_op(i, 8'(i + 1), 8'd3);
        end
        req_valid = 4'b1111;
        prev = -1;
        rep = 0;
        for (int g = 0; g < 40; g++) begin
            n = 0;
            while (resp_valid == '0 && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (resp_valid == '0) begin
                chk("soak_timeout", 32'(resp_valid), 32'd1);
                break;
            end
            for (int i = 0; i < 4; i++) begin
                if (resp_valid[i]) begin
                    cnt[i]++;
                    if (i == prev) rep++;
                    prev = i;
                end
            end
            @(negedge clk);
        end
        req_valid = '0;
        chk("soak_cnt0", 32'(cnt[0]), 32'd10);
        chk("soak_cnt1", 32'(cnt[1]), 32'd10);
        chk("soak_cnt2", 32'(cnt[2]), 32'd10);
        chk("soak_cnt3", 32'(cnt[3]), 32'd10);
        chk("soak_repeat", 32'(rep), 32'd0);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
